// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma word-copy engine.
package mem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned WORD_BYTES = 2;

endpackage

// File: rtl/mem_dma.sv
// Word-copy DMA master for the 16-bit byte-addressed memory port.
// Optional running checksum of copied words: define MEM_DMA_CHECKSUM_EN.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
`ifdef MEM_DMA_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);
    localparam logic [LEN_W-1:0]  ONE  = LEN_W'(1);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   src_ptr, src_ptr_next;
    logic [ADDR_W-1:0]   dst_ptr, dst_ptr_next;
    logic [LEN_W-1:0]    remaining, remaining_next;
    logic [DATA_W-1:0]   word_buf, word_buf_next;
    logic [ADDR_W-1:0]   mem_address_next;
    logic                busy_next, done_next, write_enable_next;
`ifdef MEM_DMA_CHECKSUM_EN
    logic [DATA_W-1:0]   checksum_next;
`endif

    // The write data bus is the captured word itself, so it holds between writes.
    assign mem_data_in = word_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            src_ptr          <= '0;
            dst_ptr          <= '0;
            remaining        <= '0;
            word_buf         <= '0;
            mem_address      <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            mem_write_enable <= 1'b0;
`ifdef MEM_DMA_CHECKSUM_EN
            checksum         <= '0;
`endif
        end else begin
            state            <= state_next;
            src_ptr          <= src_ptr_next;
            dst_ptr          <= dst_ptr_next;
            remaining        <= remaining_next;
            word_buf         <= word_buf_next;
            mem_address      <= mem_address_next;
            busy             <= busy_next;
            done             <= done_next;
            mem_write_enable <= write_enable_next;
`ifdef MEM_DMA_CHECKSUM_EN
            checksum         <= checksum_next;
`endif
        end
    end

    // Next-state and next-output values; outputs are loaded one cycle ahead of their state.
    always_comb begin
        state_next        = state;
        src_ptr_next      = src_ptr;
        dst_ptr_next      = dst_ptr;
        remaining_next    = remaining;
        word_buf_next     = word_buf;
        mem_address_next  = mem_address;
        busy_next         = busy;
        done_next         = 1'b0;
        write_enable_next = 1'b0;
`ifdef MEM_DMA_CHECKSUM_EN
        checksum_next     = checksum;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    src_ptr_next   = src_addr;
                    dst_ptr_next   = dst_addr;
                    remaining_next = length;
`ifdef MEM_DMA_CHECKSUM_EN
                    checksum_next  = '0;
`endif
                    if (length == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next       = READ;
                        busy_next        = 1'b1;
                        mem_address_next = src_addr;
                    end
                end
            end
            READ: begin
                word_buf_next     = mem_data_out;
                src_ptr_next      = src_ptr + STEP;
                state_next        = WRITE;
                mem_address_next  = dst_ptr;
                write_enable_next = 1'b1;
            end
            WRITE: begin
                dst_ptr_next   = dst_ptr + STEP;
                remaining_next = remaining - ONE;
`ifdef MEM_DMA_CHECKSUM_EN
                checksum_next  = checksum + word_buf;
`endif
                if (remaining == ONE) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    state_next       = READ;
                    mem_address_next = src_ptr;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: byte memory model, reference copy model and write/read scoreboards.
module tb_mem_dma;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] length = '0;
    logic        busy, done, mem_write_enable;
    logic [15:0] mem_address, mem_data_in, mem_data_out;
`ifdef MEM_DMA_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    wr_t         wq[$];
    logic [15:0] rq[$];
    int checks = 0;
    int fails  = 0;

    mem_dma dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable),
`ifdef MEM_DMA_CHECKSUM_EN
        .checksum(checksum),
`endif
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Little-endian byte memory: combinational read, write committed at the edge.
    assign mem_data_out = {mem[mem_address + 16'd1], mem[mem_address]};
    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_address]         = mem_data_in[7:0];
            mem[mem_address + 16'd1] = mem_data_in[15:8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return {mem[a + 16'd1], mem[a]};
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return {ref_mem[a + 16'd1], ref_mem[a]};
    endfunction

    task automatic poke_word(input logic [15:0] a, input logic [15:0] d);
        mem[a] = d[7:0];          mem[a + 16'd1] = d[15:8];
        ref_mem[a] = d[7:0];      ref_mem[a + 16'd1] = d[15:8];
    endtask

    // Forward word-by-word reference copy; only the first n_commit writes reach memory.
    task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n, input int n_commit);
        for (int i = 0; i < n; i++) begin
            logic [15:0] sa, da, w;
            sa = s + 16'(2 * i);
            da = d + 16'(2 * i);
            w  = ref_rd(sa);
            rq.push_back(sa);
            wq.push_back('{a: da, d: w});
            if (i < n_commit) begin
                ref_mem[da] = w[7:0];
                ref_mem[da + 16'd1] = w[15:8];
            end
        end
    endtask

    task automatic issue_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; length = l;
        @(posedge clk); #1;
        start = 1'b0; src_addr = 16'hDEAD; dst_addr = 16'hBEEF; length = 16'd5;
    endtask

    // Runs a full copy; poke>0 pulses a conflicting start at that cycle after acceptance.
    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input int poke);
        int busy_c, we_c, done_c;
        busy_c = 0; we_c = 0; done_c = 0;
        model_copy(s, d, int'(l), int'(l));
        issue_start(s, d, l);
        for (int c = 1; c <= 200 && done_c == 0; c++) begin
            @(negedge clk);
            if (busy) busy_c++;
            if (mem_write_enable) we_c++;
            if (done) done_c = c;
            if (c == poke) begin
                start = 1'b1; src_addr = 16'h0010; dst_addr = 16'h0500; length = 16'd2;
            end else if (c == poke + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_cycle", 32'(done_c), 32'(2 * int'(l) + 1));
        check("busy_cycles", 32'(busy_c), 32'(2 * int'(l)));
        check("we_pulses", 32'(we_c), 32'(l));
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        for (int i = 0; i < int'(l); i++)
            check("dst_word", 32'(mem_rd(d + 16'(2 * i))), 32'(ref_rd(d + 16'(2 * i))));
    endtask

    // Scoreboard: every READ cycle address and every WRITE cycle address/data.
    wr_t         exp_w;
    logic [15:0] exp_r;
    always @(negedge clk) begin
        if (!rst && mem_write_enable) begin
            if (wq.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
            else begin
                exp_w = wq.pop_front();
                check("wr_addr", 32'(mem_address), 32'(exp_w.a));
                check("wr_data", 32'(mem_data_in), 32'(exp_w.d));
            end
        end else if (!rst && busy) begin
            if (rq.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else begin
                exp_r = rq.pop_front();
                check("rd_addr", 32'(mem_address), 32'(exp_r));
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(mem_write_enable), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_wdata", 32'(mem_data_in), 32'd0);
        rst = 1'b0;

        // Basic 3-word copy
        poke_word(16'h0010, 16'h1111);
        poke_word(16'h0012, 16'h2222);
        poke_word(16'h0014, 16'h3333);
        run_copy(16'h0010, 16'h0100, 16'd3, 0);
        check("basic_w0", 32'(mem_rd(16'h0100)), 32'h1111);
        check("basic_w1", 32'(mem_rd(16'h0102)), 32'h2222);
        check("basic_w2", 32'(mem_rd(16'h0104)), 32'h3333);

        // Zero length
        run_copy(16'h0010, 16'h0180, 16'd0, 0);

        // Source pointer wrap
        poke_word(16'hFFFE, 16'hABCD);
        poke_word(16'h0000, 16'h1357);
        run_copy(16'hFFFE, 16'h0200, 16'd2, 0);
        check("wrap_w0", 32'(mem_rd(16'h0200)), 32'hABCD);
        check("wrap_w1", 32'(mem_rd(16'h0202)), 32'h1357);

        // Start pulsed mid-copy is ignored
        run_copy(16'h0010, 16'h0300, 16'd3, 3);
        check("ignored_dst", 32'(mem_rd(16'h0500)), 32'h0000);
        check("ignored_w2", 32'(mem_rd(16'h0304)), 32'h3333);

        // Overlapping forward copy propagates the first word
        poke_word(16'h0600, 16'hA0A0);
        poke_word(16'h0602, 16'hB1B1);
        poke_word(16'h0604, 16'hC2C2);
        poke_word(16'h0606, 16'hD3D3);
        run_copy(16'h0600, 16'h0602, 16'd3, 0);
        check("overlap_last", 32'(mem_rd(16'h0606)), 32'hA0A0);

        // Reset during WRITE of word 1 of a 4-word copy
        for (int i = 0; i < 4; i++) begin
            poke_word(16'h0700 + 16'(2 * i), 16'h7000 + 16'(i));
            poke_word(16'h0800 + 16'(2 * i), 16'h5A5A);
        end
        model_copy(16'h0700, 16'h0800, 2, 1);
        issue_start(16'h0700, 16'h0800, 16'd4);
        repeat (4) @(negedge clk);
        check("pre_rst_we", 32'(mem_write_enable), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_we", 32'(mem_write_enable), 32'd0);
        check("abort_addr", 32'(mem_address), 32'd0);
        check("abort_wdata", 32'(mem_data_in), 32'd0);
        check("abort_queues", 32'(wq.size() + rq.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        check("abort_w0_kept", 32'(mem_rd(16'h0800)), 32'h7000);
        check("abort_w1_absent", 32'(mem_rd(16'h0802)), 32'h5A5A);

        // Normal copy after the abort
        run_copy(16'h0700, 16'h0900, 16'd4, 0);
        check("post_rst_w3", 32'(mem_rd(16'h0906)), 32'h7003);

`ifdef MEM_DMA_CHECKSUM_EN
        poke_word(16'h0A00, 16'h8000);
        poke_word(16'h0A02, 16'h9000);
        run_copy(16'h0A00, 16'h0B00, 16'd2, 0);
        check("checksum_wrap", 32'(checksum), 32'h1000);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
